// File: rtl/dac_spi_tx.sv
// dac_spi_tx: writes one 12-bit audio sample per frame to an MCP4921-style SPI DAC.
// Each accepted sample becomes a 16-bit write {CFG_BITS, sample}, MSB first, SPI mode 0.
//
// Build option: define DAC_LDAC_PULSE_EN to add an LDAC strobe (H cycles low) after each
// CS rise. Without it, dac_ldac_n is tied low and the DAC updates on the CS rising edge.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ena             allows new samples to be accepted
//   sample          12-bit unsigned sample
//   sample_valid    sample presented; sample_ready says it is taken this cycle
//   busy            a frame is in progress
//   dac_cs_n        chip select, active low
//   dac_sclk        SPI clock, idle low
//   dac_mosi        serial data
//   dac_ldac_n      DAC latch strobe, active low
module dac_spi_tx #(
    parameter int unsigned SCLK_DIV = 2,
    parameter logic [3:0]  CFG_BITS = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [11:0] sample,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        busy,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_ldac_n
);

    localparam int unsigned DivW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StLdac,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      bit_q, bit_d;
    // Holds the bits still to be sent after the one currently on dac_mosi.
    logic [14:0]     shreg_q, shreg_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            div_last;

`ifdef DAC_LDAC_PULSE_EN
    logic            ldac_n_q, ldac_n_d;
`endif

    assign div_last     = (div_q == DivLast);
    assign sample_ready = (state_q == StIdle) & ena & ~rst;
    assign busy         = (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
`ifdef DAC_LDAC_PULSE_EN
        ldac_n_d = ldac_n_q;
`endif

        // Every non-idle state lasts a whole number of H-cycle phases.
        if (state_q != StIdle) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (sample_valid && sample_ready) begin
                    shreg_d = {CFG_BITS[2:0], sample};
                    mosi_d  = CFG_BITS[3];
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (div_last) begin
                    sclk_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (div_last) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            // Last bit stays on mosi through HOLD.
                            state_d = StHold;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            mosi_d  = shreg_q[14];
                            shreg_d = {shreg_q[13:0], 1'b0};
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (div_last) begin
                    cs_n_d   = 1'b1;
                    mosi_d   = 1'b0;
`ifdef DAC_LDAC_PULSE_EN
                    ldac_n_d = 1'b0;
                    state_d  = StLdac;
`else
                    state_d  = StGap;
`endif
                end
            end
`ifdef DAC_LDAC_PULSE_EN
            StLdac: begin
                if (div_last) begin
                    ldac_n_d = 1'b1;
                    state_d  = StGap;
                end
            end
`endif
            StGap: begin
                if (div_last) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
`ifdef DAC_LDAC_PULSE_EN
            ldac_n_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
`ifdef DAC_LDAC_PULSE_EN
            ldac_n_q <= ldac_n_d;
`endif
        end
    end

    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_mosi = mosi_q;
`ifdef DAC_LDAC_PULSE_EN
    assign dac_ldac_n = ldac_n_q;
`else
    assign dac_ldac_n = 1'b0;
`endif

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial transmitter that takes the synth's 12-bit audio sample and writes it to an external MCP4921-style SPI DAC. It sits between the synth core's `signal` output and the board pins, as the consumer end of the sample bus. Each accepted sample becomes one 16-bit SPI write: a 4-bit config nibble followed by the 12 sample bits, MSB first. An optional LDAC pulse then commits the value to the DAC output.

## Interface
Parameters:
- `SCLK_DIV`, default 2: half-period of `dac_sclk` in `clk` cycles (called H below); must be ≥1.
- `CFG_BITS`, default 4'b0011: upper nibble of every write (A/B=0, BUF=0, GA_n=1, SHDN_n=1).

Ports:
- `clk`  in  1  system clock (12 MHz on board).
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  enables acceptance of new samples.
- `sample`  in  12  unsigned sample to transmit.
- `sample_valid`  in  1  sample presented.
- `sample_ready`  out  1  block can accept a sample this cycle.
- `busy`  out  1  a frame is in progress.
- `dac_cs_n`  out  1  chip select, active low.
- `dac_sclk`  out  1  SPI clock, idle low (mode 0).
- `dac_mosi`  out  1  serial data.
- `dac_ldac_n`  out  1  DAC latch strobe, active low.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, LDAC, GAP.
- `sample_ready` = (state==IDLE) & `ena` & !`rst`. This path is combinational from `ena` and `rst`.
- **Accept** happens on the edge where `sample_valid` & `sample_ready`:
  - Latch shift register = {`CFG_BITS`, `sample`}.
  - Drive `dac_cs_n`<=0 and `dac_mosi`<=bit 15.
  - Go to SETUP with the divider cleared.
- **SETUP** (H cycles): then `dac_sclk`<=1 and go to SHIFT.
- **SHIFT**: each bit is H cycles with sclk high, then H cycles with sclk low.
  - On each high-to-low transition, `dac_mosi` advances to the next bit. The DAC samples on sclk rising edges.
  - After the 16th high phase, sclk<=0 and go to HOLD. `mosi` holds bit 0.
- **HOLD** (H cycles): then `dac_cs_n`<=1, `mosi`<=0, and go to LDAC (macro on) or GAP (macro off).
- **LDAC** (H cycles): `dac_ldac_n`=0, then go to GAP.
- **GAP** (H cycles): all outputs idle, then go to IDLE.
- `busy` = (state != IDLE).
- `ena` deasserted mid-frame: the frame completes normally. No new accept happens while `ena`=0.
- `sample` changes after accept have no effect on the current frame.
- `sample_valid` without ready is ignored; no buffering.
- **Reset values**:
  - `dac_cs_n`=1, `dac_sclk`=0, `dac_mosi`=0, `dac_ldac_n`=1, `busy`=0, `sample_ready`=0 while `rst`=1.
  - State=IDLE, divider=0, bit counter=0.
- **`rst` mid-frame**: the frame is aborted at that edge and all outputs take their reset values on the next cycle. No partial LDAC pulse is issued.

## Timing
- Accept edge = cycle 0.
- `dac_cs_n` is low for cycles 1..33H, i.e. 33H cycles.
- First sclk rising edge is at cycle H+1. The k-th rising edge (k=1..16) is at cycle H+1+2H(k-1).
- Macro on: `dac_ldac_n` is low for cycles 33H+1..34H. `sample_ready` returns high at cycle 35H+1 (frame period 35H).
- Macro off: frame period is 34H.
- Default H=2: 70-cycle frame, ≈171 kS/s maximum rate at 12 MHz.
- A new accept can occur on the first cycle `sample_ready` is high, so back-to-back frames have no extra gap.

## Configuration
- Macro `DAC_LDAC_PULSE_EN`.
- **Defined**: the LDAC state exists and `dac_ldac_n` pulses low for H cycles after each CS rise. Use this for synchronous update across frames.
- **Undefined**: the LDAC state is removed and the flow goes HOLD→GAP. `dac_ldac_n` is driven constant 0, including during reset, so the DAC updates on the CS rising edge.

## Test plan
- **Single frame**: H=2, macro on, `sample`=12'hABC accepted at cycle 0.
  - 16 sclk rising edges capture 16'h3ABC MSB first.
  - `cs_n` is low for 66 cycles and `ldac_n` is low for cycles 67..68.
  - `sample_ready` returns high at cycle 71.
- **Boundary values**: samples 12'h000 then 12'hFFF held valid back-to-back.
  - Captured words are 16'h3000 and 16'h3FFF.
  - The second accept lands exactly on the first ready cycle; sclk, cs and ldac timing is identical in both frames.
- **Reset mid-frame**: assert `rst` at cycle 20 of a frame.
  - Next cycle: `cs_n`=1, `sclk`=0, `mosi`=0, `ldac_n`=1, `busy`=0, and no LDAC pulse.
  - After release, a new sample 12'h123 transmits as 16'h3123.
- **Enable gating**: with `ena`=0 and `sample_valid`=1 for 200 cycles, `sample_ready`=0 and there is no pin activity.
  - Dropping `ena` at cycle 10 of a frame still lets that frame finish, but no further accept occurs.
- **Macro off, H=1**: `sample`=12'h800 gives word 16'h3800.
  - `cs_n` is low for 33 cycles, `ldac_n` stays constant 0, and the frame period is 34 cycles.
- **Stability check**: `sample` is changed every cycle after accept, and the captured word still equals the value at the accept edge.
